// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file destination sequencer: opcodes,
// destination-select codes and the sequencer state encoding.
package rf_seq_pkg;

  localparam int unsigned OP_BITS  = 3;
  localparam int unsigned SEL_BITS = 3;

  localparam logic [OP_BITS-1:0] OP_WR_RD = 3'd0;
  localparam logic [OP_BITS-1:0] OP_WR_RN = 3'd1;
  localparam logic [OP_BITS-1:0] OP_WR_RM = 3'd2;
  localparam logic [OP_BITS-1:0] OP_BL    = 3'd3;
  localparam logic [OP_BITS-1:0] OP_LD_WB = 3'd4;

  localparam logic [SEL_BITS-1:0] SEL_RD  = 3'd0;
  localparam logic [SEL_BITS-1:0] SEL_R15 = 3'd1;
  localparam logic [SEL_BITS-1:0] SEL_RN  = 3'd2;
  localparam logic [SEL_BITS-1:0] SEL_R14 = 3'd3;
  localparam logic [SEL_BITS-1:0] SEL_RM  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP1 = 2'd1,
    ST_STEP2 = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  function automatic logic op_two_step(input logic [OP_BITS-1:0] op);
    return (op == OP_BL) || (op == OP_LD_WB);
  endfunction

  // Select for a given write step of a legal opcode; step 0 is the first write.
  function automatic logic [SEL_BITS-1:0] step_sel(input logic [OP_BITS-1:0] op,
                                                   input logic second);
    logic [SEL_BITS-1:0] sel;
    sel = SEL_RD;
    case (op)
      OP_WR_RD: sel = SEL_RD;
      OP_WR_RN: sel = SEL_RN;
      OP_WR_RM: sel = SEL_RM;
      OP_BL:    sel = second ? SEL_R15 : SEL_R14;
      OP_LD_WB: sel = second ? SEL_RD  : SEL_RN;
      default:  sel = SEL_RD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rf_dest_sequencer.sv
// Drives the register-file destination select and write enable for one or two
// write cycles per accepted command; hold freezes the current write step.
module rf_dest_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned OP_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              cmd_ready,
  input  logic              hold,
  output logic [SEL_W-1:0]  dest_sel,
  output logic              rf_we,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  state_t             state;
  state_t             state_next;
  logic [OP_BITS-1:0] op_latched;
  logic               accept;
  logic               op_legal;
  logic               last_step;
  logic [SEL_BITS-1:0] sel;

  assign accept   = cmd_valid && (state == ST_IDLE);
  assign op_legal = (cmd_op <= OP_W'(OP_LD_WB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_latched <= '0;
    end else begin
      state <= state_next;
      if (accept) op_latched <= cmd_op[OP_BITS-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = op_legal ? ST_STEP1 : ST_ERR;
      end
      ST_STEP1: begin
        if (!hold) state_next = op_two_step(op_latched) ? ST_STEP2 : ST_IDLE;
      end
      ST_STEP2: begin
        if (!hold) state_next = ST_IDLE;
      end
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sel       = SEL_RD;
    rf_we     = 1'b0;
    last_step = 1'b0;
    case (state)
      ST_STEP1: begin
        sel       = step_sel(op_latched, 1'b0);
        rf_we     = !hold;
        last_step = !op_two_step(op_latched);
      end
      ST_STEP2: begin
        sel       = step_sel(op_latched, 1'b1);
        rf_we     = !hold;
        last_step = 1'b1;
      end
      default: begin
        sel       = SEL_RD;
        rf_we     = 1'b0;
        last_step = 1'b0;
      end
    endcase
    dest_sel  = SEL_W'(sel);
    done      = rf_we && last_step;
    cmd_err   = (state == ST_ERR);
    busy      = (state != ST_IDLE);
    cmd_ready = (state == ST_IDLE);
  end

endmodule

// File: tb/tb_rf_dest_sequencer.sv
// Randomized and directed bench for rf_dest_sequencer against a queue-based
// model of pending register writes.
module tb_rf_dest_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic       hold = 1'b0;
  logic       cmd_ready;
  logic [2:0] dest_sel;
  logic       rf_we;
  logic       busy;
  logic       done;
  logic       cmd_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: selects still to be written for the current command, plus error slot.
  int unsigned wq[$];
  logic        m_err = 1'b0;

  rf_dest_sequencer #(.SEL_W(3), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .hold(hold), .dest_sel(dest_sel), .rf_we(rf_we),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return !m_err && (wq.size() == 0);
  endfunction

  // Drive inputs after the falling edge, then compare every output with the model.
  task automatic drive_check(input logic v, input logic [2:0] op, input logic h,
                             output logic acc);
    int unsigned e_sel;
    logic e_we;
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    hold      = h;
    #1;
    e_sel = (wq.size() > 0) ? wq[0] : 0;
    e_we  = (wq.size() > 0) && !h;
    chk("cmd_ready", cmd_ready, m_ready());
    chk("busy", busy, !m_ready());
    chk("cmd_err", cmd_err, m_err);
    chk("dest_sel", dest_sel, e_sel);
    chk("rf_we", rf_we, e_we);
    chk("done", done, e_we && (wq.size() == 1));
    acc = v && m_ready();
  endtask

  // Apply the clock edge to the model using the inputs currently driven.
  task automatic advance();
    if (m_err) m_err = 1'b0;
    else if (wq.size() > 0) begin
      if (!hold) void'(wq.pop_front());
    end else if (cmd_valid) begin
      case (cmd_op)
        3'd0: wq = '{0};
        3'd1: wq = '{2};
        3'd2: wq = '{4};
        3'd3: wq = '{3, 1};
        3'd4: wq = '{2, 0};
        default: m_err = 1'b1;
      endcase
    end
    @(posedge clk);
  endtask

  initial begin
    logic acc;
    logic pend;
    logic [2:0] pop;
    logic h;
    int unsigned rf_we_seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single write, op 0
    drive_check(1'b1, 3'd0, 1'b0, acc); chk("lit_ready_after_reset", cmd_ready, 1); advance();
    drive_check(1'b0, 3'd0, 1'b0, acc);
    chk("lit_wr_rd_sel", dest_sel, 0); chk("lit_wr_rd_we", rf_we, 1); chk("lit_wr_rd_done", done, 1);
    advance();
    drive_check(1'b0, 3'd0, 1'b0, acc); chk("lit_wr_rd_ready", cmd_ready, 1); advance();

    // BL
    drive_check(1'b1, 3'd3, 1'b0, acc); advance();
    drive_check(1'b0, 3'd0, 1'b0, acc);
    chk("lit_bl_sel1", dest_sel, 3); chk("lit_bl_we1", rf_we, 1); chk("lit_bl_done1", done, 0);
    chk("lit_bl_ready1", cmd_ready, 0);
    advance();
    drive_check(1'b0, 3'd0, 1'b0, acc);
    chk("lit_bl_sel2", dest_sel, 1); chk("lit_bl_done2", done, 1); chk("lit_bl_ready2", cmd_ready, 0);
    advance();
    drive_check(1'b0, 3'd0, 1'b0, acc); chk("lit_bl_ready3", cmd_ready, 1); advance();

    // LD_WB with two hold cycles in the second step
    drive_check(1'b1, 3'd4, 1'b0, acc); advance();
    drive_check(1'b0, 3'd0, 1'b0, acc); chk("lit_ldwb_sel1", dest_sel, 2); chk("lit_ldwb_we1", rf_we, 1); advance();
    for (int i = 0; i < 2; i++) begin
      drive_check(1'b0, 3'd0, 1'b1, acc);
      chk("lit_ldwb_hold_sel", dest_sel, 0); chk("lit_ldwb_hold_we", rf_we, 0); chk("lit_ldwb_hold_done", done, 0);
      advance();
    end
    drive_check(1'b0, 3'd0, 1'b0, acc); chk("lit_ldwb_we2", rf_we, 1); chk("lit_ldwb_done", done, 1); advance();

    // Illegal opcode, with hold high during the error cycle
    drive_check(1'b1, 3'd6, 1'b0, acc); advance();
    drive_check(1'b0, 3'd0, 1'b1, acc);
    chk("lit_err_pulse", cmd_err, 1); chk("lit_err_we", rf_we, 0); chk("lit_err_ready", cmd_ready, 0);
    advance();
    drive_check(1'b0, 3'd0, 1'b0, acc); chk("lit_err_clear", cmd_err, 0); chk("lit_err_ready2", cmd_ready, 1); advance();

    // cmd_valid held across a BL: next command taken only after done
    drive_check(1'b1, 3'd3, 1'b0, acc); advance();
    drive_check(1'b1, 3'd0, 1'b0, acc); chk("lit_held_acc1", acc, 0); advance();
    drive_check(1'b1, 3'd0, 1'b0, acc); chk("lit_held_acc2", acc, 0); advance();
    drive_check(1'b1, 3'd0, 1'b0, acc); chk("lit_held_acc3", acc, 1); advance();
    drive_check(1'b0, 3'd0, 1'b0, acc); chk("lit_held_we", rf_we, 1); chk("lit_held_done", done, 1); advance();

    // Asynchronous reset during STEP1 of BL
    drive_check(1'b1, 3'd3, 1'b0, acc); advance();
    drive_check(1'b0, 3'd0, 1'b0, acc);
    reset = 1'b1;
    #1;
    chk("lit_rst_we", rf_we, 0); chk("lit_rst_done", done, 0);
    chk("lit_rst_sel", dest_sel, 0); chk("lit_rst_busy", busy, 0);
    wq.delete();
    m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rf_we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      drive_check(1'b0, 3'd0, 1'b0, acc);
      rf_we_seen += rf_we;
      advance();
    end
    chk("lit_rst_no_r15", rf_we_seen, 0);

    // Randomized traffic; the requester keeps valid and op until accepted
    pend = 1'b0;
    pop  = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1;
        pop  = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      end
      h = ($urandom_range(0, 3) == 0) && !(pend && m_ready());
      drive_check(pend, pop, h, acc);
      advance();
      if (acc) pend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
